// File: rtl/mvm_loader_pkg.sv
// Shared types for the matrix-vector engine loader.
// Holds the FSM encoding, descriptor bundle and default limits.
package mvm_loader_pkg;

    localparam int VEC_ADDRW_DEF   = 8;
    localparam int MAT_ADDRW_DEF   = 9;
    localparam int WDOG_CYCLES_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_VEC,
        S_LOAD_MAT,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    typedef struct packed {
        logic [VEC_ADDRW_DEF-1:0] vec_start;
        logic [VEC_ADDRW_DEF:0]   vec_words;
        logic [MAT_ADDRW_DEF-1:0] mat_start;
        logic [MAT_ADDRW_DEF:0]   mat_rows;
    } desc_t;

endpackage

// File: rtl/mvm_loader_addr_gen.sv
// Beat counter shared by the vector and matrix load phases.
// Produces base+offset addresses, the lane index and last-beat flag.
module mvm_loader_addr_gen
    import mvm_loader_pkg::*;
#(
    parameter int VEC_ADDRW  = VEC_ADDRW_DEF,
    parameter int MAT_ADDRW  = MAT_ADDRW_DEF,
    parameter int NUM_OLANES = 8,
    parameter int LANEW      = (NUM_OLANES > 1) ? $clog2(NUM_OLANES) : 1,
    parameter int CNTW       = ((VEC_ADDRW > MAT_ADDRW) ? VEC_ADDRW : MAT_ADDRW) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 advance,
    input  logic                 mat_phase,
    input  logic [VEC_ADDRW-1:0] vec_base,
    input  logic [VEC_ADDRW:0]   vec_len,
    input  logic [MAT_ADDRW-1:0] mat_base,
    input  logic [MAT_ADDRW:0]   mat_len,
    output logic [VEC_ADDRW-1:0] vec_addr,
    output logic [MAT_ADDRW-1:0] mat_addr,
    output logic [LANEW-1:0]     lane,
    output logic                 last
);

    logic [CNTW-1:0] idx;
    logic            row_last;
    logic            lane_last;

    assign row_last  = mat_phase ? (idx == CNTW'(mat_len) - CNTW'(1))
                                 : (idx == CNTW'(vec_len) - CNTW'(1));
    assign lane_last = (lane == LANEW'(NUM_OLANES - 1));
    assign last      = row_last & (~mat_phase | lane_last);
    assign vec_addr  = vec_base + idx[VEC_ADDRW-1:0];
    assign mat_addr  = mat_base + idx[MAT_ADDRW-1:0];

    // Offset wraps to 0 at the end of the vector so the matrix phase starts clean.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx  <= '0;
            lane <= '0;
        end else if (advance) begin
            if (row_last) begin
                idx <= '0;
                if (mat_phase) lane <= lane + LANEW'(1);
            end else begin
                idx <= idx + CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/mvm_loader.sv
// Host-side loader: descriptor + word stream -> engine writes, start, done.
// Optional busy-rise watchdog enabled by defining MVM_LOADER_WDOG_EN.
module mvm_loader
    import mvm_loader_pkg::*;
#(
    parameter int IWIDTH     = 8,
    parameter int MEM_DATAW  = IWIDTH * 8,
    parameter int VEC_ADDRW  = VEC_ADDRW_DEF,
    parameter int MAT_ADDRW  = MAT_ADDRW_DEF,
    parameter int NUM_OLANES = 8
`ifdef MVM_LOADER_WDOG_EN
    ,
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    input  logic [VEC_ADDRW-1:0]  i_cfg_vec_start_addr,
    input  logic [VEC_ADDRW:0]    i_cfg_vec_num_words,
    input  logic [MAT_ADDRW-1:0]  i_cfg_mat_start_addr,
    input  logic [MAT_ADDRW:0]    i_cfg_mat_num_rows,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    input  logic [MEM_DATAW-1:0]  i_wdata,
    output logic [MEM_DATAW-1:0]  o_vec_wdata,
    output logic [VEC_ADDRW-1:0]  o_vec_waddr,
    output logic                  o_vec_wen,
    output logic [MEM_DATAW-1:0]  o_mat_wdata,
    output logic [MAT_ADDRW-1:0]  o_mat_waddr,
    output logic [NUM_OLANES-1:0] o_mat_wen,
    output logic                  o_start,
    output logic [VEC_ADDRW-1:0]  o_vec_start_addr,
    output logic [VEC_ADDRW:0]    o_vec_num_words,
    output logic [MAT_ADDRW-1:0]  o_mat_start_addr,
    output logic [MAT_ADDRW:0]    o_mat_num_rows_per_olane,
    input  logic                  i_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int LANEW = (NUM_OLANES > 1) ? $clog2(NUM_OLANES) : 1;

    state_t               state;
    desc_t                desc;
    logic                 cfg_fire;
    logic                 wfire;
    logic                 ag_last;
    logic [VEC_ADDRW-1:0] ag_vec_addr;
    logic [MAT_ADDRW-1:0] ag_mat_addr;
    logic [LANEW-1:0]     ag_lane;

`ifdef MVM_LOADER_WDOG_EN
    localparam int WDOGW = $clog2(WDOG_CYCLES + 1);
    logic [WDOGW-1:0] wdog;
`endif

    assign cfg_fire = i_cfg_valid & o_cfg_ready;
    assign wfire    = i_wvalid & o_wready;

    assign o_vec_start_addr         = desc.vec_start;
    assign o_vec_num_words          = desc.vec_words;
    assign o_mat_start_addr         = desc.mat_start;
    assign o_mat_num_rows_per_olane = desc.mat_rows;

    mvm_loader_addr_gen #(
        .VEC_ADDRW  (VEC_ADDRW),
        .MAT_ADDRW  (MAT_ADDRW),
        .NUM_OLANES (NUM_OLANES),
        .LANEW      (LANEW)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (cfg_fire),
        .advance   (wfire),
        .mat_phase (state == S_LOAD_MAT),
        .vec_base  (desc.vec_start),
        .vec_len   (desc.vec_words),
        .mat_base  (desc.mat_start),
        .mat_len   (desc.mat_rows),
        .vec_addr  (ag_vec_addr),
        .mat_addr  (ag_mat_addr),
        .lane      (ag_lane),
        .last      (ag_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            desc        <= '0;
            o_cfg_ready <= 1'b0;
            o_wready    <= 1'b0;
            o_vec_wdata <= '0;
            o_vec_waddr <= '0;
            o_vec_wen   <= 1'b0;
            o_mat_wdata <= '0;
            o_mat_waddr <= '0;
            o_mat_wen   <= '0;
            o_start     <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
`ifdef MVM_LOADER_WDOG_EN
            wdog        <= '0;
`endif
        end else begin
            o_vec_wen <= 1'b0;
            o_mat_wen <= '0;
            o_start   <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (cfg_fire) begin
                        desc <= '{vec_start: i_cfg_vec_start_addr,
                                  vec_words: i_cfg_vec_num_words,
                                  mat_start: i_cfg_mat_start_addr,
                                  mat_rows:  i_cfg_mat_num_rows};
                        o_cfg_ready <= 1'b0;
                        if (i_cfg_vec_num_words != '0) begin
                            state    <= S_LOAD_VEC;
                            o_wready <= 1'b1;
                        end else if (i_cfg_mat_num_rows != '0) begin
                            state    <= S_LOAD_MAT;
                            o_wready <= 1'b1;
                        end else begin
                            state <= S_START;
                        end
                    end else begin
                        o_cfg_ready <= 1'b1;
                    end
                end
                S_LOAD_VEC: begin
                    if (wfire) begin
                        o_vec_wen   <= 1'b1;
                        o_vec_waddr <= ag_vec_addr;
                        o_vec_wdata <= i_wdata;
                        if (ag_last) begin
                            if (desc.mat_rows != '0) begin
                                state <= S_LOAD_MAT;
                            end else begin
                                state    <= S_START;
                                o_wready <= 1'b0;
                            end
                        end
                    end
                end
                S_LOAD_MAT: begin
                    if (wfire) begin
                        o_mat_wen   <= NUM_OLANES'(1) << ag_lane;
                        o_mat_waddr <= ag_mat_addr;
                        o_mat_wdata <= i_wdata;
                        if (ag_last) begin
                            state    <= S_START;
                            o_wready <= 1'b0;
                        end
                    end
                end
                // Entered while the final write is on the bus, so start trails it.
                S_START: begin
                    o_start <= 1'b1;
                    state   <= S_WAIT_HI;
`ifdef MVM_LOADER_WDOG_EN
                    wdog    <= '0;
`endif
                end
                S_WAIT_HI: begin
                    if (i_busy) begin
                        state <= S_WAIT_LO;
`ifdef MVM_LOADER_WDOG_EN
                    end else if (wdog == WDOGW'(WDOG_CYCLES - 1)) begin
                        o_err       <= 1'b1;
                        o_cfg_ready <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wdog <= wdog + WDOGW'(1);
`endif
                    end
                end
                S_WAIT_LO: begin
                    if (!i_busy) begin
                        o_done      <= 1'b1;
                        o_cfg_ready <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_loader.sv
// Randomised directed bench for mvm_loader against a queue-based write model.
module tb_mvm_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_cfg_valid = 1'b0;
    logic        o_cfg_ready;
    logic [7:0]  i_cfg_vec_start_addr = '0;
    logic [8:0]  i_cfg_vec_num_words = '0;
    logic [8:0]  i_cfg_mat_start_addr = '0;
    logic [9:0]  i_cfg_mat_num_rows = '0;
    logic        i_wvalid = 1'b0;
    logic        o_wready;
    logic [63:0] i_wdata = '0;
    logic [63:0] o_vec_wdata;
    logic [7:0]  o_vec_waddr;
    logic        o_vec_wen;
    logic [63:0] o_mat_wdata;
    logic [8:0]  o_mat_waddr;
    logic [7:0]  o_mat_wen;
    logic        o_start;
    logic [7:0]  o_vec_start_addr;
    logic [8:0]  o_vec_num_words;
    logic [8:0]  o_mat_start_addr;
    logic [9:0]  o_mat_num_rows_per_olane;
    logic        i_busy = 1'b0;
    logic        o_done;
    logic        o_err;

    always #5 clk = ~clk;

    mvm_loader dut (
        .clk                      (clk),
        .rst                      (rst),
        .i_cfg_valid              (i_cfg_valid),
        .o_cfg_ready              (o_cfg_ready),
        .i_cfg_vec_start_addr     (i_cfg_vec_start_addr),
        .i_cfg_vec_num_words      (i_cfg_vec_num_words),
        .i_cfg_mat_start_addr     (i_cfg_mat_start_addr),
        .i_cfg_mat_num_rows       (i_cfg_mat_num_rows),
        .i_wvalid                 (i_wvalid),
        .o_wready                 (o_wready),
        .i_wdata                  (i_wdata),
        .o_vec_wdata              (o_vec_wdata),
        .o_vec_waddr              (o_vec_waddr),
        .o_vec_wen                (o_vec_wen),
        .o_mat_wdata              (o_mat_wdata),
        .o_mat_waddr              (o_mat_waddr),
        .o_mat_wen                (o_mat_wen),
        .o_start                  (o_start),
        .o_vec_start_addr         (o_vec_start_addr),
        .o_vec_num_words          (o_vec_num_words),
        .o_mat_start_addr         (o_mat_start_addr),
        .o_mat_num_rows_per_olane (o_mat_num_rows_per_olane),
        .i_busy                   (i_busy),
        .o_done                   (o_done),
        .o_err                    (o_err)
    );

    typedef struct packed {
        logic        is_mat;
        logic [7:0]  lanes;
        logic [8:0]  addr;
        logic [63:0] data;
    } wr_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cnt = 0, done_cnt = 0, err_cnt = 0;
    int start_cyc = 0, done_cyc = 0, err_cyc = 0, last_wen_cyc = 0;
    wr_t exp_q[$];
    logic [63:0] words[$];
    wr_t mon_o, mon_e;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every beat must match the next modelled write.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_vec_wen || o_mat_wen != '0) begin
                check("wen_exclusive", 128'(o_vec_wen && o_mat_wen != '0), 128'(0));
                check("mat_wen_onehot", 128'($onehot0(o_mat_wen)), 128'(1));
                mon_o.is_mat = (o_mat_wen != '0);
                mon_o.lanes  = o_mat_wen;
                mon_o.addr   = mon_o.is_mat ? o_mat_waddr : {1'b0, o_vec_waddr};
                mon_o.data   = mon_o.is_mat ? o_mat_wdata : o_vec_wdata;
                check("wen_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("write_beat", 128'(mon_o), 128'(mon_e));
                end
                last_wen_cyc = cyc;
            end
            if (o_start) begin start_cnt++; start_cyc = cyc; end
            if (o_done)  begin done_cnt++;  done_cyc  = cyc; end
            if (o_err)   begin err_cnt++;   err_cyc   = cyc; end
        end
    end

    task automatic push_expected(input logic [7:0] vs, input logic [8:0] nw,
                                 input logic [8:0] ms, input logic [9:0] nr);
        wr_t w;
        logic [63:0] d;
        words.delete();
        for (int k = 0; k < int'(nw); k++) begin
            d = {$urandom, $urandom};
            words.push_back(d);
            w.is_mat = 1'b0;
            w.lanes  = 8'h00;
            w.addr   = {1'b0, 8'((int'(vs) + k) % 256)};
            w.data   = d;
            exp_q.push_back(w);
        end
        for (int l = 0; l < 8; l++) begin
            for (int r = 0; r < int'(nr); r++) begin
                d = {$urandom, $urandom};
                words.push_back(d);
                w.is_mat = 1'b1;
                w.lanes  = 8'(1 << l);
                w.addr   = 9'((int'(ms) + r) % 512);
                w.data   = d;
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic send_cfg(input logic [7:0] vs, input logic [8:0] nw,
                            input logic [8:0] ms, input logic [9:0] nr, output int hs);
        int t = 0;
        @(negedge clk);
        i_cfg_vec_start_addr = vs;
        i_cfg_vec_num_words  = nw;
        i_cfg_mat_start_addr = ms;
        i_cfg_mat_num_rows   = nr;
        i_cfg_valid          = 1'b1;
        while (!o_cfg_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("cfg_ready_wait", 128'(o_cfg_ready), 128'(1));
        hs = cyc;
        @(posedge clk);
        #1;
        i_cfg_valid = 1'b0;
        check("desc_latched",
              {o_vec_start_addr, o_vec_num_words, o_mat_start_addr, o_mat_num_rows_per_olane},
              {vs, nw, ms, nr});
    endtask

    task automatic stream(input int gap, input int limit);
        int idx = 0;
        int guard = 0;
        while (idx < limit && guard < 5000) begin
            @(negedge clk);
            guard++;
            i_wvalid = ($urandom_range(99) >= gap);
            i_wdata  = words[idx];
            if (i_wvalid && o_wready) idx++;
        end
        check("stream_consumed", 128'(idx), 128'(limit));
        @(negedge clk);
        i_wvalid = 1'b0;
    endtask

    task automatic wait_start(input int s0);
        int t = 0;
        while (start_cnt == s0 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
    endtask

    task automatic run_job(input logic [7:0] vs, input logic [8:0] nw,
                           input logic [8:0] ms, input logic [9:0] nr,
                           input int gap, input int busy_len);
        int hs, fall, t;
        int s0 = start_cnt;
        int d0 = done_cnt;
        push_expected(vs, nw, ms, nr);
        send_cfg(vs, nw, ms, nr, hs);
        stream(gap, words.size());
        wait_start(s0);
        check("start_seen", 128'(start_cnt - s0), 128'(1));
        if (nw == '0 && nr == '0)
            check("start_timing_empty", 128'(start_cyc), 128'(hs + 2));
        else
            check("start_after_last_wen", 128'(start_cyc), 128'(last_wen_cyc + 1));
        check("writes_drained", 128'(exp_q.size()), 128'(0));
        repeat (2) @(negedge clk);
        i_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        i_busy = 1'b0;
        fall = cyc;
        t = 0;
        while (done_cnt == d0 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("done_count", 128'(done_cnt - d0), 128'(1));
        check("done_timing", 128'(done_cyc), 128'(fall + 1));
        check("single_start", 128'(start_cnt - s0), 128'(1));
        check("cfg_ready_after_done", 128'(o_cfg_ready), 128'(1));
    endtask

    initial begin
        int hs, s0, d0, t;

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {o_cfg_ready, o_wready, o_vec_wen, o_mat_wen, o_start, o_done, o_err,
               o_vec_waddr, o_mat_waddr, o_vec_wdata, o_vec_num_words, o_mat_num_rows_per_olane},
              '0);
        rst = 1'b0;

        i_wvalid = 1'b1;
        i_wdata  = 64'hDEAD_BEEF_0000_0001;
        repeat (4) @(negedge clk);
        check("idle_wready_low", 128'(o_wready), 128'(0));
        check("idle_cfg_ready", 128'(o_cfg_ready), 128'(1));
        i_wvalid = 1'b0;

        run_job(8'h10, 9'd2, 9'h020, 10'd1, 0, 5);
        run_job(8'h00, 9'd0, 9'h000, 10'd0, 0, 3);
        run_job(8'h10, 9'd2, 9'h020, 10'd1, 45, 5);
        run_job(8'hFE, 9'd4, 9'h1FF, 10'd2, 30, 2);
        run_job(8'h05, 9'd0, 9'h100, 10'd3, 20, 1);
        for (int j = 0; j < 4; j++) begin
            run_job(8'($urandom), 9'($urandom_range(6)), 9'($urandom),
                    10'($urandom_range(3)), $urandom_range(50), $urandom_range(1, 6));
        end

        // Abandon a job while lane 3 of the matrix is loading.
        s0 = start_cnt;
        push_expected(8'h30, 9'd1, 9'h040, 10'd2);
        send_cfg(8'h30, 9'd1, 9'h040, 10'd2, hs);
        stream(0, 1 + 3 * 2 + 1);
        rst = 1'b1;
        @(negedge clk);
        check("midjob_reset_outputs",
              {o_cfg_ready, o_wready, o_vec_wen, o_mat_wen, o_start, o_done, o_err,
               o_mat_waddr, o_mat_wdata, o_vec_start_addr, o_mat_num_rows_per_olane},
              '0);
        rst = 1'b0;
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("no_start_after_reset", 128'(start_cnt - s0), 128'(0));
        run_job(8'h7F, 9'd3, 9'h0F0, 10'd2, 25, 4);

`ifdef MVM_LOADER_WDOG_EN
        s0 = start_cnt;
        d0 = done_cnt;
        push_expected(8'h00, 9'd1, 9'h000, 10'd0);
        send_cfg(8'h00, 9'd1, 9'h000, 10'd0, hs);
        stream(0, 1);
        wait_start(s0);
        t = err_cnt;
        begin
            int g = 0;
            while (err_cnt == t && g < 100) begin
                @(negedge clk);
                #1;
                g++;
            end
        end
        check("wdog_err_count", 128'(err_cnt - t), 128'(1));
        check("wdog_err_timing", 128'(err_cyc), 128'(start_cyc + 16));
        repeat (5) @(negedge clk);
        check("wdog_no_done", 128'(done_cnt - d0), 128'(0));
        check("wdog_cfg_ready", 128'(o_cfg_ready), 128'(1));
        run_job(8'h22, 9'd2, 9'h011, 10'd1, 10, 3);
`else
        check("err_never", 128'(err_cnt), 128'(0));
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mvm_loader.md
Name: mvm_loader

Overview:
Host-side initiator for the matrix-vector multiply engine.
- Accepts one job descriptor, then a single valid/ready word stream.
- Turns the stream into vector-memory and per-lane matrix-memory write transactions.
- Pulses the engine start with the job's addresses and sizes, then tracks the engine busy flag until the job completes.
- Sits between the host/DMA stream and the engine's write and start ports.

Parameters:
IWIDTH, 8, element width in bits
MEM_DATAW, IWIDTH*8, memory word width (8 elements per word)
VEC_ADDRW, 8, vector memory address width
MAT_ADDRW, 9, matrix memory address width
NUM_OLANES, 8, number of output lanes (matrix memories)
WDOG_CYCLES, 16, busy-rise watchdog limit (used only when MVM_LOADER_WDOG_EN is defined)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_cfg_valid  in  1  descriptor valid
o_cfg_ready  out  1  descriptor accepted when valid&ready
i_cfg_vec_start_addr  in  VEC_ADDRW  vector base address
i_cfg_vec_num_words  in  VEC_ADDRW+1  vector length in words
i_cfg_mat_start_addr  in  MAT_ADDRW  matrix base address
i_cfg_mat_num_rows  in  MAT_ADDRW+1  words per lane
i_wvalid  in  1  stream word valid
o_wready  out  1  stream word ready
i_wdata  in  MEM_DATAW  stream word
o_vec_wdata  out  MEM_DATAW  to engine vector write data
o_vec_waddr  out  VEC_ADDRW  to engine vector write address
o_vec_wen  out  1  to engine vector write enable
o_mat_wdata  out  MEM_DATAW  to engine matrix write data
o_mat_waddr  out  MAT_ADDRW  to engine matrix write address
o_mat_wen  out  NUM_OLANES  to engine one-hot lane write enable
o_start  out  1  to engine start pulse
o_vec_start_addr  out  VEC_ADDRW  latched descriptor field
o_vec_num_words  out  VEC_ADDRW+1  latched descriptor field
o_mat_start_addr  out  MAT_ADDRW  latched descriptor field
o_mat_num_rows_per_olane  out  MAT_ADDRW+1  latched descriptor field
i_busy  in  1  engine busy
o_done  out  1  one-cycle job-complete pulse
o_err  out  1  one-cycle watchdog error pulse (tied 0 without the macro)

Behaviour:
- Reset values: all outputs 0, including o_cfg_ready and o_wready; FSM in IDLE.
- Reset mid-job: abandons the job immediately; no further wen or start is issued.
- FSM states: IDLE, LOAD_VEC, LOAD_MAT, START, WAIT_HI, WAIT_LO.
- IDLE:
  - o_cfg_ready=1.
  - On cfg handshake, latch all descriptor fields and clear counters.
  - Next state is LOAD_VEC if num_words>0, else LOAD_MAT if num_rows>0, else START.
- LOAD_VEC:
  - o_wready=1.
  - Each handshake writes word k to vector address start+k, modulo 2^VEC_ADDRW.
  - After word num_words-1, go to LOAD_MAT (or START if num_rows==0).
- LOAD_MAT:
  - o_wready=1.
  - Order is lane-major: lane 0 rows 0..R-1, then lane 1, and so on up to lane NUM_OLANES-1.
  - Row r of lane l goes to address mat_start+r (mod 2^MAT_ADDRW) with o_mat_wen=1<<l.
  - After the final beat, go to START.
- Write outputs are registered:
  - wen, addr and data appear exactly 1 cycle after the handshake; wen is high for 1 cycle per beat.
  - Back-to-back beats give continuous wen.
  - o_vec_wen and o_mat_wen are never both high.
- START: o_start=1 for exactly 1 cycle, then go to WAIT_HI.
  - The START entry cycle coincides with the last write's wen, so the final word is in memory before the engine's first read.
- WAIT_HI: wait for i_busy=1, then go to WAIT_LO.
- WAIT_LO: wait for i_busy=0, then pulse o_done for 1 cycle and return to IDLE.
- Ready gating: o_cfg_ready=0 outside IDLE; o_wready=0 outside the LOAD states. Stream words offered in other states are not consumed.
- Descriptor outputs hold their latched values from acceptance until the next acceptance.

Optional Feature:
MVM_LOADER_WDOG_EN
- Defined: a counter runs in WAIT_HI. If i_busy has not risen within WDOG_CYCLES cycles after o_start, pulse o_err for 1 cycle, return to IDLE, and do not pulse o_done.
- Undefined: WAIT_HI waits indefinitely and o_err is constant 0.

Decomposition:
- Package mvm_loader_pkg holds:
  - FSM state enum type.
  - Descriptor struct type (four fields).
  - Default WDOG_CYCLES constant.
- One natural sub-module: mvm_loader_addr_gen. It contains the base+offset counters, the lane index, and last-beat detection, and is reused for both vector and matrix phases.

Test Plan:
- Basic job: cfg vec_start=0x10, words=2, mat_start=0x20, rows=1; stream 10 words -> vec writes at 0x10,0x11; then lane l write at 0x20 with wen=1<<l for l=0..7; then one o_start; busy 1 for 5 cycles -> o_done once after busy falls.
- Empty phases: words=0, rows=0 -> no wen at all; o_start on the 2nd cycle after cfg handshake.
- Backpressure/gaps: randomly deassert i_wvalid -> write sequence, addresses and data identical to the gap-free run; no duplicate wen.
- Wrap: vec_start=0xFE, words=4 -> addresses 0xFE,0xFF,0x00,0x01; mat_start=0x1FF, rows=2 -> 0x1FF,0x000 per lane.
- Reset mid-LOAD_MAT (lane 3): all outputs 0 on the next cycle; o_start never pulses; a new job afterwards runs correctly.
- With MVM_LOADER_WDOG_EN: i_busy held 0 -> o_err pulse 16 cycles after o_start, o_done never asserts, o_cfg_ready returns to 1.
